// File: rtl/common_axis_pkg.sv
// Shared definitions for the AXI4-Stream master/sink pair: width helper,
// FSM state encoding and the TSTRB all-ones mask.
package common_axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } axis_state_e;

    // Bits needed to hold the value itself (not value-1), so 128 -> 8.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [127:0] strb_ones(input int nbytes);
        return (128'(1) << nbytes) - 128'(1);
    endfunction

endpackage

// File: rtl/common_m00_axis.sv
// AXI4-Stream master: snapshots a wide buffer on send_start and streams it out
// word 0 first, one beat per accepted handshake, TLAST on word L-1.
module common_m00_axis
    import common_axis_pkg::*;
#(
    parameter  int C_M_AXIS_TDATA_WIDTH   = 8,
    parameter  int NUMBER_OF_OUTPUT_WORDS = 128,
    localparam int CNT_W                  = clogb2(NUMBER_OF_OUTPUT_WORDS)
) (
    input  logic                                             M_AXIS_ACLK,
    input  logic                                             M_AXIS_ARESETN,
    input  logic [C_M_AXIS_TDATA_WIDTH*NUMBER_OF_OUTPUT_WORDS-1:0] data_to_send,
    input  logic                                             send_start,
    input  logic [CNT_W-1:0]                                 num_words,
    output logic                                             busy,
    output logic                                             send_done,
    output logic                                             M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]                  M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                M_AXIS_TSTRB,
    output logic                                             M_AXIS_TLAST,
    input  logic                                             M_AXIS_TREADY
);

    localparam int W      = C_M_AXIS_TDATA_WIDTH;
    localparam int N      = NUMBER_OF_OUTPUT_WORDS;
    localparam int STRB_W = W / 8;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_ones(STRB_W));
    localparam logic [CNT_W-1:0]  N_CNT     = CNT_W'(N);

    axis_state_e               state_q;
    logic [N-1:0][W-1:0]       snap_q;
    logic [CNT_W-1:0]          ptr_q, len_q;
    logic                      tvalid_q, tlast_q, busy_q, done_q;
    logic [W-1:0]              tdata_q;
    logic [STRB_W-1:0]         tstrb_q;

    logic [CNT_W-1:0]          len_d, ptr_d;
    logic [IDX_W-1:0]          idx_d;
    logic                      last_beat;

    // 0 and anything above N both mean a full buffer.
    assign len_d     = (num_words == '0 || num_words > N_CNT) ? N_CNT : num_words;
    assign ptr_d     = ptr_q + CNT_W'(1);
    assign idx_d     = IDX_W'(ptr_d);
    assign last_beat = (ptr_q == len_q - CNT_W'(1));

    // Snapshot has no reset; it is only read after a capture.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (state_q == IDLE && send_start && M_AXIS_ARESETN)
            snap_q <= data_to_send;
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            len_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (send_start) begin
                        // Word 0 comes straight from the input: snapshot loads this same edge.
                        len_q    <= len_d;
                        ptr_q    <= '0;
                        tvalid_q <= 1'b1;
                        tdata_q  <= data_to_send[W-1:0];
                        tlast_q  <= (len_d == CNT_W'(1));
                        tstrb_q  <= STRB_ONES;
                        busy_q   <= 1'b1;
                        state_q  <= SEND;
                    end
                end
                SEND: begin
                    if (M_AXIS_TREADY) begin
                        if (last_beat) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            tstrb_q  <= '0;
                            tdata_q  <= '0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            ptr_q   <= ptr_d;
                            tdata_q <= snap_q[idx_d];
                            tlast_q <= (ptr_d == len_q - CNT_W'(1));
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign send_done     = done_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = tstrb_q;
    assign M_AXIS_TLAST  = tlast_q;

endmodule
